regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file. Shares that port between three requesters: pipeline writeback, the multi-cycle load unit and the debug port.
- After reset, it sequences a clear of x1..x31 before any requester is served.
- Sits between the writeback stage and the register file's reg_write / rd / rd_write_data inputs.
- Read ports are not touched.

Parameters:
- XLEN, 32, data width of register file entries.
- CLEAR_ON_RESET, 1, 1 = run the x1..x31 clear sequence after reset; 0 = go straight to RUN.
- CLEAR_VALUE, 0, XLEN-bit value written to each register during the clear.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  pipeline writeback request; cannot be stalled.
- wb_rd  in  5  writeback destination register.
- wb_data  in  XLEN  writeback data.
- ld_valid  in  1  load unit write request.
- ld_ready  out  1  load request accepted this cycle (combinational).
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  load data.
- dbg_valid  in  1  debug write request.
- dbg_ready  out  1  debug request accepted this cycle (combinational).
- dbg_rd  in  5  debug destination register.
- dbg_data  in  XLEN  debug data.
- rf_we  out  1  register file write enable (registered).
- rf_rd  out  5  register file write address (registered).
- rf_wdata  out  XLEN  register file write data (registered).
- init_done  out  1  high once the clear has finished; the pipeline must hold writeback until this is high.
- wb_drop_err  out  1  sticky flag: a wb_valid arrived while not in RUN.

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - state = CLEAR, or RUN if CLEAR_ON_RESET=0.
  - clear counter = 1, rr_pri = LD.
  - rf_we=0, rf_rd=0, rf_wdata=0.
  - init_done = 0, or 1 if CLEAR_ON_RESET=0.
  - wb_drop_err = 0.
- State CLEAR:
  - Each edge registers rf_we=1, rf_rd=counter, rf_wdata=CLEAR_VALUE, then increments the counter.
  - Writes x1..x31 on 31 consecutive cycles, starting the first cycle after rst falls.
  - On the edge that registers the write for counter=31, state goes to RUN and init_done goes to 1.
  - The write to x31 is therefore on the bus while init_done is first high.
  - ld_ready = dbg_ready = 0 throughout.
  - If wb_valid=1 during CLEAR: the request is discarded and wb_drop_err is set.
- State RUN: one grant per cycle, fixed priority, evaluated combinationally.
  - Priority 1: wb_valid=1 → wb is granted; ld_ready=0, dbg_ready=0.
  - Priority 2: otherwise, if exactly one of ld_valid / dbg_valid is high, that requester gets ready=1.
  - If both are high, the requester named by rr_pri wins. rr_pri then flips to the other requester after the accepted transfer.
  - rr_pri changes only on an accepted ld or dbg transfer.
  - ready is asserted only when the matching valid is high.
  - Requesters hold valid, rd and data stable until ready.
- Output registration: a grant at edge N drives rf_we/rf_rd/rf_wdata during cycle N+1. The register file commits at edge N+1, so write latency is 1 cycle from acceptance.
- rd = 0: the request is accepted (ready=1) but rf_we is registered as 0. rf_rd and rf_wdata still update.
- No grant in a cycle: rf_we=0 next cycle; rf_rd and rf_wdata hold their values.
- No state returns to CLEAR except via rst. Reset mid-clear restarts the clear at x1.
- wb_drop_err is cleared only by rst.
- Estimated RTL size: about 150 lines.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, CLEAR_VALUE=0 → rf_we=1 with rf_rd = 1,2,…,31 on 31 consecutive cycles, rf_wdata=0. init_done rises together with rf_rd=31. Next cycle rf_we=0.
- RUN, wb_valid=1 with wb_rd=5, wb_data=0xDEADBEEF, and ld_valid=1 in the same cycle → ld_ready=0. Next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF. The load is accepted the following cycle once wb_valid drops.
- RUN, ld_valid and dbg_valid held high for 4 cycles, no wb → grants alternate ld, dbg, ld, dbg, starting with ld after reset. rf_rd follows the corresponding requester's rd one cycle later.
- ld_valid=1 with ld_rd=0, ld_data=0x1234 → ld_ready=1, next cycle rf_we=0. A read of x0 stays 0.
- wb_valid=1 at cycle 10 of CLEAR → wb_drop_err=1 from the next edge and stays 1. The clear sequence is unaffected. rst clears the flag.
- rst asserted at clear step 12 (asynchronously, mid-cycle) → rf_we drops to 0 immediately. After release the clear restarts at rf_rd=1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file.
// After reset it clears x1..x31 (optional), then grants one of three writers
// per cycle: pipeline writeback (highest, never stalled), then load unit and
// debug port sharing the remaining slots with a two-way round-robin.
// The register file write port (rf_we/rf_rd/rf_wdata) is registered, so a
// request accepted at edge N is committed by the register file at edge N+1.
module regfile_write_arbiter #(
    parameter int              XLEN           = 32,
    parameter bit              CLEAR_ON_RESET = 1'b1,
    parameter logic [XLEN-1:0] CLEAR_VALUE    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            dbg_valid,
    output logic            dbg_ready,
    input  logic [4:0]      dbg_rd,
    input  logic [XLEN-1:0] dbg_data,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            init_done,
    output logic            wb_drop_err
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Which of the two stallable requesters wins when both ask at once.
    typedef enum logic {
        PRI_LD  = 1'b0,
        PRI_DBG = 1'b1
    } pri_t;

    localparam logic [4:0] LAST_REG = 5'd31;

    state_t            state;
    state_t            state_next;
    pri_t              rr_pri;
    logic [4:0]        clr_cnt;
    logic              clr_last;

    logic              wb_gnt;
    logic              ld_gnt;
    logic              dbg_gnt;
    logic              any_gnt;
    logic [4:0]        sel_rd;
    logic [XLEN-1:0]   sel_data;

    assign clr_last = (clr_cnt == LAST_REG);

    // Next-state and grant decode; grants only ever happen in RUN.
    always_comb begin
        state_next = state;
        wb_gnt     = 1'b0;
        ld_gnt     = 1'b0;
        dbg_gnt    = 1'b0;
        if (state == ST_CLEAR) begin
            if (clr_last) begin
                state_next = ST_RUN;
            end
        end else begin
            if (wb_valid) begin
                wb_gnt = 1'b1;
            end else if (ld_valid && (!dbg_valid || rr_pri == PRI_LD)) begin
                ld_gnt = 1'b1;
            end else if (dbg_valid) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    assign ld_ready  = ld_gnt;
    assign dbg_ready = dbg_gnt;
    assign any_gnt   = wb_gnt | ld_gnt | dbg_gnt;

    // Address/data of the granted requester.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        if (wb_gnt) begin
            sel_rd   = wb_rd;
            sel_data = wb_data;
        end else if (ld_gnt) begin
            sel_rd   = ld_rd;
            sel_data = ld_data;
        end else if (dbg_gnt) begin
            sel_rd   = dbg_rd;
            sel_data = dbg_data;
        end
    end

    // FSM state register; CLEAR is only re-entered through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Clear address counter: walks x1..x31 while clearing, restarts at x1 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= 5'd1;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 5'd1;
        end
    end

    // Registered write port: clear writes, granted writes, or idle (address/data held).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (state == ST_CLEAR) begin
            rf_we    <= 1'b1;
            rf_rd    <= clr_cnt;
            rf_wdata <= CLEAR_VALUE;
        end else if (any_gnt) begin
            // x0 is hardwired: the transfer completes but nothing is written.
            rf_we    <= (sel_rd != 5'd0);
            rf_rd    <= sel_rd;
            rf_wdata <= sel_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Round-robin pointer: after an accepted load/debug transfer the other side is favoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_pri <= PRI_LD;
        end else if (ld_gnt) begin
            rr_pri <= PRI_DBG;
        end else if (dbg_gnt) begin
            rr_pri <= PRI_LD;
        end
    end

    // init_done rises on the same edge that puts the x31 clear write on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done <= !CLEAR_ON_RESET;
        end else if (state == ST_CLEAR && clr_last) begin
            init_done <= 1'b1;
        end
    end

    // Sticky error: writeback cannot be stalled, so one arriving before RUN is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_drop_err <= 1'b0;
        end else if (state != ST_RUN && wb_valid) begin
            wb_drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: reset/clear sequence, table of
// arbitration vectors, randomized traffic against a register-file model,
// and an asynchronous reset in the middle of the clear.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [4:0]  dbg_rd;
    logic [31:0] dbg_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        init_done;
    logic        wb_drop_err;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter #(
        .XLEN(32),
        .CLEAR_ON_RESET(1'b1),
        .CLEAR_VALUE(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_rd(ld_rd),
        .ld_data(ld_data),
        .dbg_valid(dbg_valid),
        .dbg_ready(dbg_ready),
        .dbg_rd(dbg_rd),
        .dbg_data(dbg_data),
        .rf_we(rf_we),
        .rf_rd(rf_rd),
        .rf_wdata(rf_wdata),
        .init_done(init_done),
        .wb_drop_err(wb_drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wv;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        logic        dv;
        logic [4:0]  dr;
        logic [31:0] dd;
        logic        e_lrdy;
        logic        e_drdy;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
    } vec_t;

    function automatic vec_t mk(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                                input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                                input logic dv, input logic [4:0] dr, input logic [31:0] dd,
                                input logic e_lrdy, input logic e_drdy, input logic e_we,
                                input logic [4:0] e_rd, input logic [31:0] e_wd);
        vec_t v;
        v.wv = wv; v.wr = wr; v.wd = wd;
        v.lv = lv; v.lr = lr; v.ld = ld;
        v.dv = dv; v.dr = dr; v.dd = dd;
        v.e_lrdy = e_lrdy; v.e_drdy = e_drdy;
        v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd;
        return v;
    endfunction

    vec_t tbl[11];

    // Reference model state for the random phase.
    logic [31:0] model_rf [32];
    logic [31:0] shadow_rf [32];
    bit          ld_pend, dbg_pend, favour_ld;
    logic [4:0]  m_ld_rd, m_dbg_rd;
    logic [31:0] m_ld_d, m_dbg_d;
    bit          exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;

    initial begin
        rst = 1'b1;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h1;
        dbg_valid = 1; dbg_rd = 5'd4; dbg_data = 32'h2;

        // ---------------- reset state ----------------
        repeat (2) step();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_drop_err", wb_drop_err, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_dbg_ready", dbg_ready, 0);
        ld_valid = 0;

        // ---------------- clear sequence, wb dropped at clear step 10 ----------------
        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            step();
            chk($sformatf("clr%0d_we", k), rf_we, 1);
            chk($sformatf("clr%0d_rd", k), rf_rd, k[4:0]);
            chk($sformatf("clr%0d_wdata", k), rf_wdata, 0);
            chk($sformatf("clr%0d_init_done", k), init_done, (k == 31) ? 1 : 0);
            chk($sformatf("clr%0d_drop_err", k), wb_drop_err, (k >= 11) ? 1 : 0);
            if (k < 31) chk($sformatf("clr%0d_dbg_ready", k), dbg_ready, 0);
            if (k == 10) begin
                wb_valid = 1; wb_rd = 5'd6; wb_data = 32'hCAFE;
            end
            if (k == 11) wb_valid = 0;
        end
        dbg_valid = 0;
        step();
        chk("post_clear_we", rf_we, 0);
        chk("post_clear_init_done", init_done, 1);
        chk("post_clear_drop_err", wb_drop_err, 1);

        // ---------------- arbitration vectors ----------------
        tbl[0]  = mk(1, 5'd5, 32'hDEADBEEF, 1, 5'd7, 32'h11110007, 0, 5'd0, 32'h0,   0, 0, 1, 5'd5,  32'hDEADBEEF);
        tbl[1]  = mk(0, 5'd0, 32'h0,        1, 5'd7, 32'h11110007, 1, 5'd9, 32'h33,  1, 0, 1, 5'd7,  32'h11110007);
        tbl[2]  = mk(0, 5'd0, 32'h0,        1, 5'd8, 32'h22,       1, 5'd9, 32'h33,  0, 1, 1, 5'd9,  32'h33);
        tbl[3]  = mk(0, 5'd0, 32'h0,        1, 5'd8, 32'h22,       1, 5'd11, 32'h55, 1, 0, 1, 5'd8,  32'h22);
        tbl[4]  = mk(0, 5'd0, 32'h0,        1, 5'd10, 32'h44,      1, 5'd11, 32'h55, 0, 1, 1, 5'd11, 32'h55);
        tbl[5]  = mk(0, 5'd0, 32'h0,        1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,   1, 0, 0, 5'd0,  32'h1234);
        tbl[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'h0,   0, 0, 0, 5'd0,  32'h1234);
        tbl[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd3, 32'hA5A5, 0, 1, 1, 5'd3, 32'hA5A5);
        tbl[8]  = mk(1, 5'd0, 32'hFFFF,     0, 5'd0, 32'h0,        1, 5'd4, 32'h77,  0, 0, 0, 5'd0,  32'hFFFF);
        tbl[9]  = mk(0, 5'd0, 32'h0,        1, 5'd12, 32'h88,      1, 5'd4, 32'h77,  1, 0, 1, 5'd12, 32'h88);
        tbl[10] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd4, 32'h77,  0, 1, 1, 5'd4,  32'h77);

        for (int i = 0; i < 11; i++) begin
            wb_valid = tbl[i].wv;  wb_rd = tbl[i].wr;  wb_data = tbl[i].wd;
            ld_valid = tbl[i].lv;  ld_rd = tbl[i].lr;  ld_data = tbl[i].ld;
            dbg_valid = tbl[i].dv; dbg_rd = tbl[i].dr; dbg_data = tbl[i].dd;
            #1;
            chk($sformatf("v%0d_ld_ready", i), ld_ready, tbl[i].e_lrdy);
            chk($sformatf("v%0d_dbg_ready", i), dbg_ready, tbl[i].e_drdy);
            step();
            chk($sformatf("v%0d_rf_we", i), rf_we, tbl[i].e_we);
            chk($sformatf("v%0d_rf_rd", i), rf_rd, tbl[i].e_rd);
            chk($sformatf("v%0d_rf_wdata", i), rf_wdata, tbl[i].e_wd);
        end
        wb_valid = 0; ld_valid = 0; dbg_valid = 0;

        // ---------------- randomized traffic vs register-file model ----------------
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = 32'h0;
            shadow_rf[i] = 32'h0;
        end
        ld_pend = 0; dbg_pend = 0; favour_ld = 1;
        exp_rd = 5'd4; exp_wd = 32'h77;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit   g_wb, g_ld, g_dbg;
            wb_valid = ($urandom_range(0, 3) == 0);
            wb_rd = 5'($urandom_range(0, 31));
            wb_data = $urandom;
            if (!ld_pend && $urandom_range(0, 1) == 1) begin
                ld_pend = 1; m_ld_rd = 5'($urandom_range(0, 31)); m_ld_d = $urandom;
            end
            if (!dbg_pend && $urandom_range(0, 1) == 1) begin
                dbg_pend = 1; m_dbg_rd = 5'($urandom_range(0, 31)); m_dbg_d = $urandom;
            end
            ld_valid = ld_pend;   ld_rd = m_ld_rd;   ld_data = m_ld_d;
            dbg_valid = dbg_pend; dbg_rd = m_dbg_rd; dbg_data = m_dbg_d;

            g_wb = wb_valid;
            g_ld = !g_wb && ld_pend && (!dbg_pend || favour_ld);
            g_dbg = !g_wb && !g_ld && dbg_pend;
            #1;
            chk("rnd_ld_ready", ld_ready, g_ld);
            chk("rnd_dbg_ready", dbg_ready, g_dbg);

            exp_we = 0;
            if (g_wb) begin
                exp_rd = wb_rd; exp_wd = wb_data;
            end else if (g_ld) begin
                exp_rd = m_ld_rd; exp_wd = m_ld_d; ld_pend = 0; favour_ld = 0;
            end else if (g_dbg) begin
                exp_rd = m_dbg_rd; exp_wd = m_dbg_d; dbg_pend = 0; favour_ld = 1;
            end
            if ((g_wb || g_ld || g_dbg) && exp_rd != 0) begin
                exp_we = 1;
                model_rf[exp_rd] = exp_wd;
            end
            step();
            chk("rnd_rf_we", rf_we, exp_we);
            chk("rnd_rf_rd", rf_rd, exp_rd);
            chk("rnd_rf_wdata", rf_wdata, exp_wd);
            if (rf_we) shadow_rf[rf_rd] = rf_wdata;
        end
        wb_valid = 0; ld_valid = 0; dbg_valid = 0;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("rf_x%0d", i), shadow_rf[i], model_rf[i]);
        end
        chk("drop_err_sticky", wb_drop_err, 1);

        // ---------------- asynchronous reset in the middle of the clear ----------------
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("mid%0d_rd", k), rf_rd, k[4:0]);
        end
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_we", rf_we, 0);
        chk("async_rst_rd", rf_rd, 0);
        chk("async_rst_init_done", init_done, 0);
        chk("async_rst_drop_err", wb_drop_err, 0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            step();
            chk($sformatf("re%0d_we", k), rf_we, 1);
            chk($sformatf("re%0d_rd", k), rf_rd, k[4:0]);
            chk($sformatf("re%0d_init_done", k), init_done, (k == 31) ? 1 : 0);
        end
        step();
        chk("re_post_we", rf_we, 0);
        chk("re_drop_err", wb_drop_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
